// File: rtl/bitsim_pkg.sv
// bitsim_pkg: shared FSM state type and default operand width for the bit-serial datapath
package bitsim_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/abs_sign_split.sv
// abs_sign_split: combinational split of a two's-complement word into sign and unsigned magnitude
//   data in  W  signed operand
//   sign out 1  1 = negative
//   mag  out W  |data| as unsigned; the most-negative value maps to 2^(W-1)
module abs_sign_split #(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  output logic         sign,
  output logic [W-1:0] mag
);
  assign sign = data[W-1];
  assign mag = sign ? -data : data;
endmodule

// File: rtl/signmag_bit_serializer.sv
// signmag_bit_serializer: streams |in_data| LSB-first one bit per beat with the sign held per word
//   clk, rst_n                   clock, async active-low reset
//   in_data/in_valid/in_ready    operand handshake
//   out_sign/out_bit/out_idx     current beat: word sign, magnitude bit, bit position
//   out_last/out_valid/out_ready beat framing and handshake
//   busy                         word in flight
module signmag_bit_serializer
  import bitsim_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit SKIP_ZERO_MSB = 1'b1,
  localparam int IDX_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_sign,
  output logic                  out_bit,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] mag_q, mag_in;
  logic [IDX_W-1:0] idx_q;
  logic sign_q, sign_in, last, fire, accept;
  abs_sign_split #(.W(DATA_WIDTH)) u_split (.data(in_data), .sign(sign_in), .mag(mag_in));
  assign busy = state_q == SHIFT;
  // mag_q shifts right each beat, so bit 0 is always the current beat and
  // everything above it is what remains to be sent
  assign last = SKIP_ZERO_MSB ? (mag_q >> 1) == '0 : idx_q == IDX_W'(DATA_WIDTH - 1);
  assign out_valid = busy;
  assign out_sign = busy & sign_q;
  assign out_bit = busy & mag_q[0];
  assign out_last = busy & last;
  assign out_idx = idx_q;
  assign fire = out_valid & out_ready;
  // accepting on the final beat lets the next word follow with no idle cycle
  assign in_ready = !busy | (fire & last);
  assign accept = in_valid & in_ready;
  always_comb begin
    state_d = state_q;
    state_d = accept ? SHIFT : (fire & last) ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q <= '0;
      sign_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mag_q <= mag_in;
        sign_q <= sign_in;
        idx_q <= '0;
      end else if (fire) begin
        mag_q <= mag_q >> 1;
        idx_q <= last ? '0 : idx_q + IDX_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_signmag_bit_serializer.sv
// tb_signmag_bit_serializer: randomized model-checked bench over a full-width and a skip-zero instance
module tb_signmag_bit_serializer;
  typedef struct {bit sign; bit b; int idx; bit last;} beat_t;
  typedef struct {int n; logic [7:0] bits; bit sign;} rec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] in_data [2];
  logic in_valid [2], in_ready [2], out_sign [2], out_bit [2], out_last [2], out_valid [2], out_ready [2], busy [2];
  logic [2:0] out_idx [2];
  beat_t exp_q [2][$];
  logic [7:0] word_q [2][$];
  logic [7:0] stim_q [2][$];
  rec_t rec_q [2][$];
  logic [7:0] rb [2];
  int nb [2];
  bit acc [2];
  bit stall = 0, gaps = 0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  // lane 0: always DATA_WIDTH beats; lane 1: stop after the top set bit
  signmag_bit_serializer #(.DATA_WIDTH(8), .SKIP_ZERO_MSB(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_sign(out_sign[0]), .out_bit(out_bit[0]), .out_idx(out_idx[0]), .out_last(out_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0]));
  signmag_bit_serializer #(.DATA_WIDTH(8), .SKIP_ZERO_MSB(1'b1)) u_skip (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_sign(out_sign[1]), .out_bit(out_bit[1]), .out_idx(out_idx[1]), .out_last(out_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1]));
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int mag_of(logic [7:0] v);
    int s = int'($signed(v));
    return s < 0 ? -s : s;
  endfunction
  function automatic int nbeats(int m, bit sk);
    if (!sk) return 8;
    for (int i = 7; i >= 0; i--) if (m >= (1 << i)) return i + 1;
    return 1;
  endfunction
  task automatic push_word(int l, logic [7:0] v);
    int m = mag_of(v);
    int n = nbeats(m, l == 1);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.sign = v[7];
      b.b = m[i];
      b.idx = i;
      b.last = i == n - 1;
      exp_q[l].push_back(b);
    end
    word_q[l].push_back(v);
  endtask
  task automatic chk_idle(int l, string tag);
    chk($sformatf("%s out_valid[%0d]", tag, l), int'(out_valid[l]), 0);
    chk($sformatf("%s busy[%0d]", tag, l), int'(busy[l]), 0);
    chk($sformatf("%s out_idx[%0d]", tag, l), int'(out_idx[l]), 0);
    chk($sformatf("%s out_sign[%0d]", tag, l), int'(out_sign[l]), 0);
    chk($sformatf("%s out_bit[%0d]", tag, l), int'(out_bit[l]), 0);
    chk($sformatf("%s out_last[%0d]", tag, l), int'(out_last[l]), 0);
  endtask
  task automatic cycle();
    bit fire [2], accm [2], rdy;
    logic bit_s [2], sign_s [2];
    logic [2:0] idx_s [2];
    logic [7:0] w, v;
    beat_t b;
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      if (exp_q[l].size() > 0) begin
        b = exp_q[l][0];
        chk($sformatf("out_valid[%0d]", l), int'(out_valid[l]), 1);
        chk($sformatf("busy[%0d]", l), int'(busy[l]), 1);
        chk($sformatf("out_sign[%0d]", l), int'(out_sign[l]), int'(b.sign));
        chk($sformatf("out_bit[%0d]", l), int'(out_bit[l]), int'(b.b));
        chk($sformatf("out_idx[%0d]", l), int'(out_idx[l]), b.idx);
        chk($sformatf("out_last[%0d]", l), int'(out_last[l]), int'(b.last));
      end else chk_idle(l, "idle");
    end
    #1;
    for (int l = 0; l < 2; l++) begin
      if (acc[l]) begin
        in_valid[l] = 1'b0;
        acc[l] = 0;
      end
      if (!in_valid[l] && stim_q[l].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        in_data[l] = stim_q[l].pop_front();
        in_valid[l] = 1'b1;
      end
      out_ready[l] = !stall || $urandom_range(2) != 0;
    end
    #3;
    for (int l = 0; l < 2; l++) begin
      rdy = exp_q[l].size() == 0 || (out_ready[l] && exp_q[l][0].last);
      chk($sformatf("in_ready[%0d]", l), int'(in_ready[l]), int'(rdy));
      fire[l] = exp_q[l].size() > 0 && out_ready[l];
      accm[l] = in_valid[l] && rdy;
      bit_s[l] = out_bit[l];
      sign_s[l] = out_sign[l];
      idx_s[l] = out_idx[l];
    end
    @(posedge clk);
    for (int l = 0; l < 2; l++) begin
      if (fire[l]) begin
        b = exp_q[l].pop_front();
        if (b.idx == 0) begin
          rb[l] = '0;
          nb[l] = 0;
        end
        rb[l][idx_s[l]] = bit_s[l];
        nb[l]++;
        if (b.last) begin
          w = word_q[l].pop_front();
          v = sign_s[l] ? -rb[l] : rb[l];
          chk($sformatf("rebuild[%0d]", l), int'(v), int'(w));
          rec_q[l].push_back('{nb[l], rb[l], sign_s[l]});
        end
      end
      if (accm[l]) begin
        push_word(l, in_data[l]);
        acc[l] = 1;
      end
    end
  endtask
  task automatic drain(int budget);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      cycle();
      done = 1;
      for (int l = 0; l < 2; l++)
        if (stim_q[l].size() > 0 || exp_q[l].size() > 0 || (in_valid[l] && !acc[l])) done = 0;
    end
    chk("drain timeout", int'(done), 1);
  endtask
  task automatic expect_rec(int l, int n, logic [7:0] bits, bit sign, string tag);
    rec_t r;
    chk($sformatf("%s word present", tag), int'(rec_q[l].size() > 0), 1);
    if (rec_q[l].size() > 0) begin
      r = rec_q[l].pop_front();
      chk($sformatf("%s beats", tag), r.n, n);
      chk($sformatf("%s bits", tag), int'(r.bits), int'(bits));
      chk($sformatf("%s sign", tag), int'(r.sign), int'(sign));
    end
  endtask
  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) begin
      chk_idle(l, "async reset");
      chk($sformatf("async reset in_ready[%0d]", l), int'(in_ready[l]), 1);
      exp_q[l].delete();
      word_q[l].delete();
      in_valid[l] = 1'b0;
      acc[l] = 0;
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask
  initial begin
    logic [7:0] r;
    for (int l = 0; l < 2; l++) begin
      in_valid[l] = 1'b0;
      in_data[l] = '0;
      out_ready[l] = 1'b1;
      acc[l] = 0;
      rb[l] = '0;
      nb[l] = 0;
    end
    #1;
    for (int l = 0; l < 2; l++) begin
      chk_idle(l, "reset");
      chk($sformatf("reset in_ready[%0d]", l), int'(in_ready[l]), 1);
    end
    chk("model mag 0x80", mag_of(8'h80), 128);
    chk("model beats 5 skip", nbeats(mag_of(8'h05), 1), 3);
    chk("model beats 0 skip", nbeats(mag_of(8'h00), 1), 1);
    chk("model beats -6 full", nbeats(mag_of(8'hFA), 0), 8);
    @(negedge clk);
    #2 rst_n = 1'b1;
    stim_q[1].push_back(8'h05);
    drain(100);
    expect_rec(1, 3, 8'h05, 0, "t1 +5");
    stim_q[0].push_back(8'hFA);
    drain(100);
    expect_rec(0, 8, 8'h06, 1, "t2 -6");
    stim_q[1].push_back(8'h80);
    drain(100);
    expect_rec(1, 8, 8'h80, 1, "t3 -128");
    stim_q[1].push_back(8'h00);
    drain(100);
    expect_rec(1, 1, 8'h00, 0, "t4 zero");
    stim_q[1].push_back(8'h03);
    stim_q[1].push_back(8'hFF);
    drain(100);
    expect_rec(1, 2, 8'h03, 0, "t5 +3");
    expect_rec(1, 1, 8'h01, 1, "t5 -1");
    stall = 1;
    gaps = 1;
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < 40; i++)
        for (int l = 0; l < 2; l++) begin
          r = 8'($urandom_range(255));
          if (l == 0 && r == 8'h00) r = 8'h01;
          stim_q[l].push_back(r);
        end
      for (int k = 0; k < 60 + int'($urandom_range(40)); k++) cycle();
      for (int k = 0; k < 50 && !(out_valid[0] && out_valid[1]); k++) cycle();
      reset_mid();
    end
    drain(8000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
